// File: rtl/regfile_sb.sv
// Multi-port integer register file with a per-register pending scoreboard.
// Two combinational read ports, two prioritised write ports (A over B), optional write bypass.
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_ready,
    output logic            rs2_ready,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    input  logic            wa_en,
    input  logic [AW-1:0]   wa_addr,
    input  logic [XLEN-1:0] wa_data,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic [AW:0]     pend_cnt
);

    localparam int NREGS = 1 << AW;

    logic [XLEN-1:0] regs [NREGS];
    logic [NREGS-1:0] pend;
    logic [NREGS-1:0] pend_next;
    logic [AW:0]      cnt_next;
    logic             wa_commit;
    logic             wb_commit;
    logic             iss_eff;
    logic             set_inc;
    logic             clr_a;
    logic             clr_b;
    logic [AW-1:0]    rd_addr  [2];
    logic [XLEN-1:0]  rd_data  [2];
    logic             rd_ready [2];

    // Port B is squashed when port A hits the same register, so at most one commit per address.
    always_comb begin
        wa_commit = wa_en && !(ZERO_REG != 0 && wa_addr == '0);
        wb_commit = wb_en && !(ZERO_REG != 0 && wb_addr == '0)
                    && !(wa_commit && wa_addr == wb_addr);
        iss_eff   = iss_valid && !(ZERO_REG != 0 && iss_rd == '0);
    end

    always_comb begin
        pend_next = pend;
        if (wa_commit) pend_next[wa_addr] = 1'b0;
        if (wb_commit) pend_next[wb_addr] = 1'b0;
        if (iss_eff)   pend_next[iss_rd]  = 1'b1;
        if (flush)     pend_next          = '0;
    end

    // Count tracks only real 0->1 and 1->0 transitions; a clear masked by a same-cycle issue is not one.
    always_comb begin
        set_inc  = iss_eff && !pend[iss_rd];
        clr_a    = wa_commit && pend[wa_addr] && !(iss_eff && iss_rd == wa_addr);
        clr_b    = wb_commit && pend[wb_addr] && !(iss_eff && iss_rd == wb_addr);
        cnt_next = pend_cnt + {{AW{1'b0}}, set_inc}
                            - {{AW{1'b0}}, clr_a}
                            - {{AW{1'b0}}, clr_b};
        if (flush) cnt_next = '0;
    end

    always_comb begin
        rd_addr[0] = rs1_addr;
        rd_addr[1] = rs2_addr;
        for (int p = 0; p < 2; p++) begin
            rd_data[p]  = regs[rd_addr[p]];
            rd_ready[p] = !pend[rd_addr[p]];
            if (BYPASS != 0 && wa_commit && wa_addr == rd_addr[p]) begin
                rd_data[p]  = wa_data;
                rd_ready[p] = 1'b1;
            end else if (BYPASS != 0 && wb_commit && wb_addr == rd_addr[p]) begin
                rd_data[p]  = wb_data;
                rd_ready[p] = 1'b1;
            end
            if (ZERO_REG != 0 && rd_addr[p] == '0) begin
                rd_data[p]  = '0;
                rd_ready[p] = 1'b1;
            end
            if (!rst_n) begin
                rd_data[p]  = '0;
                rd_ready[p] = 1'b1;
            end
        end
    end

    assign rs1_data  = rd_data[0];
    assign rs2_data  = rd_data[1];
    assign rs1_ready = rd_ready[0];
    assign rs2_ready = rd_ready[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            if (wa_commit) regs[wa_addr] <= wa_data;
            if (wb_commit) regs[wb_addr] <= wb_data;
            pend     <= pend_next;
            pend_cnt <= cnt_next;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: two configurations driven in parallel against an array model.
// Instance 0 has ZERO_REG=1/BYPASS=1, instance 1 has ZERO_REG=0/BYPASS=0.
module tb_regfile_sb;

    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int NREGS = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [AW-1:0]   rs1_addr, rs2_addr, iss_rd, wa_addr, wb_addr;
    logic            iss_valid, wa_en, wb_en, flush;
    logic [XLEN-1:0] wa_data, wb_data;

    logic [XLEN-1:0] d0_rs1_data, d0_rs2_data, d1_rs1_data, d1_rs2_data;
    logic            d0_rs1_ready, d0_rs2_ready, d1_rs1_ready, d1_rs2_ready;
    logic [AW:0]     d0_pend_cnt, d1_pend_cnt;

    logic [XLEN-1:0] m_regs [2][NREGS];
    bit              m_pend [2][NREGS];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(XLEN), .AW(AW), .ZERO_REG(1), .BYPASS(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(d0_rs1_data), .rs2_data(d0_rs2_data),
        .rs1_ready(d0_rs1_ready), .rs2_ready(d0_rs2_ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush), .pend_cnt(d0_pend_cnt)
    );

    regfile_sb #(.XLEN(XLEN), .AW(AW), .ZERO_REG(0), .BYPASS(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(d1_rs1_data), .rs2_data(d1_rs2_data),
        .rs1_ready(d1_rs1_ready), .rs2_ready(d1_rs2_ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush), .pend_cnt(d1_pend_cnt)
    );

    function automatic bit cfg_zero(int c);
        return c == 0;
    endfunction

    function automatic bit cfg_byp(int c);
        return c == 0;
    endfunction

    function automatic logic [XLEN-1:0] exp_data(int c, logic [AW-1:0] a);
        if (!rst_n) return '0;
        if (cfg_zero(c) && a == 0) return '0;
        if (cfg_byp(c) && wa_en && wa_addr == a) return wa_data;
        if (cfg_byp(c) && wb_en && wb_addr == a) return wb_data;
        return m_regs[c][a];
    endfunction

    function automatic logic [XLEN-1:0] exp_ready(int c, logic [AW-1:0] a);
        if (!rst_n) return 1;
        if (cfg_zero(c) && a == 0) return 1;
        if (!m_pend[c][a]) return 1;
        if (cfg_byp(c) && ((wa_en && wa_addr == a) || (wb_en && wb_addr == a))) return 1;
        return 0;
    endfunction

    function automatic logic [XLEN-1:0] exp_cnt(int c);
        int n = 0;
        for (int i = 0; i < NREGS; i++) if (m_pend[c][i]) n++;
        return XLEN'(n);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < NREGS; i++) begin
                m_regs[c][i] = '0;
                m_pend[c][i] = 1'b0;
            end
    endtask

    // Port B is written first so that port A overwrites it on an address clash.
    task automatic model_edge();
        for (int c = 0; c < 2; c++) begin
            bit wa_ok = wa_en && !(cfg_zero(c) && wa_addr == 0);
            bit wb_ok = wb_en && !(cfg_zero(c) && wb_addr == 0);
            if (wb_ok) m_regs[c][wb_addr] = wb_data;
            if (wa_ok) m_regs[c][wa_addr] = wa_data;
            if (flush) begin
                for (int i = 0; i < NREGS; i++) m_pend[c][i] = 1'b0;
            end else begin
                if (wa_ok) m_pend[c][wa_addr] = 1'b0;
                if (wb_ok) m_pend[c][wb_addr] = 1'b0;
                if (iss_valid && !(cfg_zero(c) && iss_rd == 0)) m_pend[c][iss_rd] = 1'b1;
            end
        end
    endtask

    task automatic check(string tag, logic [XLEN-1:0] obs, logic [XLEN-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_output();
        check("d0_rs1_data",  d0_rs1_data,                 exp_data(0, rs1_addr));
        check("d0_rs2_data",  d0_rs2_data,                 exp_data(0, rs2_addr));
        check("d0_rs1_ready", XLEN'(d0_rs1_ready),         exp_ready(0, rs1_addr));
        check("d0_rs2_ready", XLEN'(d0_rs2_ready),         exp_ready(0, rs2_addr));
        check("d0_pend_cnt",  XLEN'(d0_pend_cnt),          exp_cnt(0));
        check("d1_rs1_data",  d1_rs1_data,                 exp_data(1, rs1_addr));
        check("d1_rs2_data",  d1_rs2_data,                 exp_data(1, rs2_addr));
        check("d1_rs1_ready", XLEN'(d1_rs1_ready),         exp_ready(1, rs1_addr));
        check("d1_rs2_ready", XLEN'(d1_rs2_ready),         exp_ready(1, rs2_addr));
        check("d1_pend_cnt",  XLEN'(d1_pend_cnt),          exp_cnt(1));
    endtask

    task automatic apply_stimulus(logic [AW-1:0] r1, logic [AW-1:0] r2);
        rs1_addr  = r1;
        rs2_addr  = r2;
        iss_valid = 1'b0;
        iss_rd    = '0;
        wa_en     = 1'b0;
        wa_addr   = '0;
        wa_data   = '0;
        wb_en     = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        flush     = 1'b0;
    endtask

    task automatic settle();
        #3;
        check_output();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        apply_stimulus(5'd0, 5'd0);
        model_reset();
        #1 rst_n = 1'b0;
        #1 check_output();
        check("reset_pend_cnt", XLEN'(d0_pend_cnt), 0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] dual-write conflict");
        apply_stimulus(5'd7, 5'd0);
        wa_en = 1; wa_addr = 7; wa_data = 32'h11;
        wb_en = 1; wb_addr = 7; wb_data = 32'h22;
        settle(); tick();
        apply_stimulus(5'd7, 5'd0);
        settle();
        check("conflict_d0", d0_rs1_data, 32'h11);
        check("conflict_d1", d1_rs1_data, 32'h11);
        tick();
        apply_stimulus(5'd3, 5'd4);
        wa_en = 1; wa_addr = 3; wa_data = 32'h33;
        wb_en = 1; wb_addr = 4; wb_data = 32'h44;
        settle(); tick();
        apply_stimulus(5'd3, 5'd4);
        settle();
        check("both_a", d1_rs1_data, 32'h33);
        check("both_b", d1_rs2_data, 32'h44);
        tick();

        $display("[TB] bypass");
        apply_stimulus(5'd0, 5'd9);
        wa_en = 1; wa_addr = 9; wa_data = 32'h1234;
        settle(); tick();
        apply_stimulus(5'd0, 5'd9);
        wa_en = 1; wa_addr = 9; wa_data = 32'hCAFE;
        settle();
        check("bypass_on", d0_rs2_data, 32'hCAFE);
        check("bypass_off", d1_rs2_data, 32'h1234);
        tick();
        apply_stimulus(5'd0, 5'd9);
        settle();
        check("bypass_off_after", d1_rs2_data, 32'hCAFE);
        tick();

        $display("[TB] scoreboard");
        apply_stimulus(5'd10, 5'd0);
        iss_valid = 1; iss_rd = 10;
        settle(); tick();
        apply_stimulus(5'd10, 5'd0);
        settle();
        check("issue_ready", XLEN'(d0_rs1_ready), 0);
        check("issue_cnt", XLEN'(d0_pend_cnt), 1);
        tick();
        apply_stimulus(5'd10, 5'd0);
        wb_en = 1; wb_addr = 10; wb_data = 32'h5;
        settle();
        check("wb_ready_byp", XLEN'(d0_rs1_ready), 1);
        check("wb_ready_nobyp", XLEN'(d1_rs1_ready), 0);
        tick();
        apply_stimulus(5'd10, 5'd0);
        settle();
        check("wb_cnt", XLEN'(d0_pend_cnt), 0);
        tick();
        apply_stimulus(5'd10, 5'd0);
        iss_valid = 1; iss_rd = 10;
        wa_en = 1; wa_addr = 10; wa_data = 32'h7;
        settle(); tick();
        apply_stimulus(5'd10, 5'd0);
        settle();
        check("set_wins", XLEN'(d0_rs1_ready), 0);
        tick();
        apply_stimulus(5'd10, 5'd0);
        wa_en = 1; wa_addr = 10; wa_data = 32'h8;
        settle(); tick();

        $display("[TB] flush");
        for (int r = 1; r <= 3; r++) begin
            apply_stimulus(5'd1, 5'd2);
            iss_valid = 1; iss_rd = AW'(r);
            settle(); tick();
        end
        apply_stimulus(5'd1, 5'd3);
        settle();
        check("pre_flush_cnt", XLEN'(d0_pend_cnt), 3);
        flush = 1; iss_valid = 1; iss_rd = 4;
        wa_en = 1; wa_addr = 1; wa_data = 32'h9;
        settle(); tick();
        apply_stimulus(5'd1, 5'd4);
        settle();
        check("flush_cnt", XLEN'(d0_pend_cnt), 0);
        check("flush_ready4", XLEN'(d0_rs2_ready), 1);
        check("flush_data", d0_rs1_data, 32'h9);
        tick();

        $display("[TB] zero register");
        apply_stimulus(5'd0, 5'd0);
        iss_valid = 1; iss_rd = 0;
        wa_en = 1; wa_addr = 0; wa_data = 32'hFF;
        settle();
        check("zero_data_now", d0_rs1_data, 0);
        tick();
        apply_stimulus(5'd0, 5'd0);
        settle();
        check("zero_data", d0_rs1_data, 0);
        check("zero_ready", XLEN'(d0_rs1_ready), 1);
        check("zero_cnt", XLEN'(d0_pend_cnt), 0);
        check("reg0_plain", d1_rs1_data, 32'hFF);
        tick();

        $display("[TB] asynchronous reset");
        apply_stimulus(5'd5, 5'd0);
        wa_en = 1; wa_addr = 5; wa_data = 32'hDEADBEEF;
        iss_valid = 1; iss_rd = 5;
        settle(); tick();
        apply_stimulus(5'd5, 5'd0);
        settle();
        check("pre_rst_data", d0_rs1_data, 32'hDEADBEEF);
        check("pre_rst_ready", XLEN'(d0_rs1_ready), 0);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_output();
        check("rst_data", d0_rs1_data, 0);
        check("rst_ready", XLEN'(d0_rs1_ready), 1);
        check("rst_cnt", XLEN'(d0_pend_cnt), 0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            apply_stimulus(AW'($urandom_range(0, 11)), AW'($urandom_range(0, 11)));
            iss_valid = ($urandom_range(0, 9) < 4);
            iss_rd    = AW'($urandom_range(0, 11));
            wa_en     = ($urandom_range(0, 1) == 1);
            wa_addr   = AW'($urandom_range(0, 11));
            wa_data   = $urandom;
            wb_en     = ($urandom_range(0, 1) == 1);
            wb_addr   = AW'($urandom_range(0, 11));
            wb_data   = $urandom;
            flush     = ($urandom_range(0, 15) == 0);
            settle(); tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
